// File: rtl/rf_scan_ctrl.sv
// Register-file scan sequencer: borrows the RF read port between core reads and
// streams every (index, value) pair out over a valid/ready dump interface.
module rf_scan_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              core_rd_req,
    output logic              core_stall,
    output logic              rf_port_sel,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [XLEN-1:0]   dump_data
);

    // A zero limit still needs a 1-bit counter that simply never increments.
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [XLEN-1:0]   buf_q, buf_d;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            starve_q <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            starve_q <= starve_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        starve_d = starve_q;
        buf_d    = buf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ARB;
                    idx_d    = '0;
                    starve_d = '0;
                end
            end
            S_ARB: begin
                // Yield to the core until the starvation bound forces the port.
                if (!core_rd_req || starve_q == STARVE_MAX) begin
                    state_d  = S_ISSUE;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + SW'(1);
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT: begin
                buf_d   = rf_rdata;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_ARB;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign rf_port_sel = (state_q == S_ISSUE);
    assign core_stall  = rf_port_sel & core_rd_req;
    assign rf_raddr    = rf_port_sel ? idx_q : '0;
    assign dump_valid  = (state_q == S_SEND);
    assign dump_addr   = dump_valid ? idx_q : '0;
    assign dump_data   = dump_valid ? buf_q : '0;

endmodule

// File: tb/tb_rf_scan_ctrl.sv
// Self-checking bench for rf_scan_ctrl: scenario table plus scoreboard of
// expected dump beats, and hand-written reset sequences.
module tb_rf_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start;
    logic        busy;
    logic        done;
    logic        core_rd_req;
    logic        core_stall;
    logic        rf_port_sel;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } beat_t;
    beat_t sb[$];

    // req_mode: 0 = idle core, 1 = core always requesting, 2 = toggling
    typedef struct {
        int req_mode;
        int hold_beat;
        int restart_beat;
        int exp_done;
        int exp_stalls;
    } vec_t;
    vec_t vecs[5];

    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) rf_rdata <= rf_mem[rf_raddr];

    rf_scan_ctrl #(
        .NUM_REGS    (32),
        .XLEN        (32),
        .ADDR_W      (5),
        .STARVE_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .core_rd_req(core_rd_req),
        .core_stall (core_stall),
        .rf_port_sel(rf_port_sel),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    function automatic logic [31:0] exp_val(input int i);
        return (i == 0) ? 32'h0 : (32'hA500_0000 + 32'(i));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_scan();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.a = 5'(i);
            b.d = exp_val(i);
            sb.push_back(b);
        end
    endtask

    task automatic pop_check();
        beat_t b;
        if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(dump_addr), 64'hFFFF);
        end else begin
            b = sb.pop_front();
            chk("beat_addr", 64'(dump_addr), 64'(b.a));
            chk("beat_data", 64'(dump_data), 64'(b.d));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  64'(busy),        64'd0);
        chk({tag, "_done"},  64'(done),        64'd0);
        chk({tag, "_stall"}, 64'(core_stall),  64'd0);
        chk({tag, "_sel"},   64'(rf_port_sel), 64'd0);
        chk({tag, "_raddr"}, 64'(rf_raddr),    64'd0);
        chk({tag, "_valid"}, 64'(dump_valid),  64'd0);
        chk({tag, "_daddr"}, 64'(dump_addr),   64'd0);
        chk({tag, "_ddata"}, 64'(dump_data),   64'd0);
    endtask

    task automatic run_scan(input vec_t v);
        int c = 0, stalls = 0, held = 0, beats = 0;
        bit done_seen = 0, restarted = 0, prev_sel = 0;
        @(negedge clk);
        start = 1'b1;
        core_rd_req = 1'b0;
        dump_ready = 1'b1;
        push_scan();
        while (!done_seen && c < 3000) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            core_rd_req = (v.req_mode == 1) ? 1'b1 : (v.req_mode == 2) ? ((c % 2) == 1) : 1'b0;
            dump_ready = 1'b1;
            if (v.hold_beat >= 0 && dump_valid && int'(dump_addr) == v.hold_beat && held < 5) begin
                dump_ready = 1'b0;
                chk("hold_addr", 64'(dump_addr), 64'(v.hold_beat));
                chk("hold_data", 64'(dump_data), 64'(exp_val(v.hold_beat)));
                held++;
            end
            if (v.restart_beat >= 0 && dump_valid && int'(dump_addr) == v.restart_beat && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
            #1;
            chk("busy_during_scan", 64'(busy), 64'd1);
            if (core_stall) begin
                stalls++;
                chk("stall_only_in_issue", 64'(rf_port_sel), 64'd1);
            end
            if (v.req_mode == 2 && prev_sel)
                chk("port_sel_back_to_back", 64'(rf_port_sel), 64'd0);
            prev_sel = rf_port_sel;
            if (dump_valid && dump_ready) begin
                pop_check();
                beats++;
            end
            if (done) begin
                done_seen = 1;
                if (v.exp_done > 0) chk("done_cycle", 64'(c), 64'(v.exp_done));
            end
        end
        if (!done_seen) chk("done_timeout", 64'(c), 64'(v.exp_done));
        chk("beat_count", 64'(beats), 64'd32);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        if (v.exp_stalls >= 0) chk("stall_count", 64'(stalls), 64'(v.exp_stalls));
        else chk("stall_count_bound", 64'(stalls <= 32), 64'd1);
        if (v.hold_beat >= 0) chk("hold_cycles", 64'(held), 64'd5);
        @(negedge clk);
        #1;
        chk("post_done_pulse", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        sb.delete();
    endtask

    initial begin
        int n;
        vecs[0] = '{req_mode: 0, hold_beat: -1, restart_beat: -1, exp_done: 129, exp_stalls: 0};
        vecs[1] = '{req_mode: 1, hold_beat: -1, restart_beat: -1, exp_done: 385, exp_stalls: 32};
        vecs[2] = '{req_mode: 0, hold_beat:  7, restart_beat: -1, exp_done: 134, exp_stalls: 0};
        vecs[3] = '{req_mode: 0, hold_beat: -1, restart_beat: 10, exp_done: 129, exp_stalls: 0};
        vecs[4] = '{req_mode: 2, hold_beat: -1, restart_beat: -1, exp_done: -1,  exp_stalls: -1};

        for (int i = 0; i < 32; i++) rf_mem[i] = exp_val(i);

        rstb = 1'b0;
        start = 1'b1;
        core_rd_req = 1'b1;
        dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rstb = 1'b1;
        start = 1'b0;
        core_rd_req = 1'b0;

        for (int i = 0; i < 5; i++) run_scan(vecs[i]);

        // Reset during SEND of beat 15 abandons the scan silently.
        @(negedge clk);
        start = 1'b1;
        push_scan();
        n = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            dump_ready = 1'b1;
            n++;
            #1;
            if ((dump_valid && dump_addr == 5'd15) || n > 200) break;
            if (dump_valid && dump_ready) pop_check();
        end
        chk("reach_beat15", 64'(dump_addr), 64'd15);
        rstb = 1'b0;
        dump_ready = 1'b0;
        core_rd_req = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("midscan_reset");
        rstb = 1'b1;
        core_rd_req = 1'b0;
        dump_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done || busy || dump_valid) n++;
        end
        chk("idle_after_reset", 64'(n), 64'd0);
        sb.delete();
        run_scan(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rf_scan_ctrl.md
Name: rf_scan_ctrl

Overview:
Debug sequencer that walks every architectural register of the core register file through its read port and streams each (index, value) pair out on a valid/ready interface. It sits beside the register file in philosophy_v_core and borrows the read port only when the core is not using it. A bounded starvation counter forces ownership so a scan always completes. Benches use it for end-of-run register dumps instead of hierarchical peeks.

Parameters:
NUM_REGS, 32, number of registers scanned (indices 0..NUM_REGS-1)
XLEN, 32, register data width
ADDR_W, 5, register index width, clog2(NUM_REGS)
STARVE_LIMIT, 8, max ARB cycles spent yielding to the core before forcing the port; 0 = always force

Ports:
clk  in  1  system clock, all state on rising edge
rstb  in  1  synchronous active-low reset
start  in  1  begin a scan; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last register is accepted
core_rd_req  in  1  core needs the RF read port this cycle
core_stall  out  1  core must hold its read this cycle (= rf_port_sel & core_rd_req)
rf_port_sel  out  1  1 = this block drives the RF read address
rf_raddr  out  ADDR_W  read address to RF, valid when rf_port_sel=1
rf_rdata  in  XLEN  RF read data, synchronous read: valid the cycle after the address
dump_valid  out  1  dump beat valid
dump_ready  in  1  sink accepts beat
dump_addr  out  ADDR_W  register index of the beat
dump_data  out  XLEN  register value of the beat

Behaviour:
- Reset (rstb=0 at a clock edge): state=IDLE, idx=0, starve_cnt=0, data buffer=0; busy, done, core_stall, rf_port_sel, dump_valid all 0; rf_raddr, dump_addr, dump_data = 0. Reset mid-scan abandons the scan; no done pulse.
- States: IDLE, ARB, ISSUE, CAPT, SEND, DONE. All outputs decode from registered state/idx/buffer; no input-to-output combinational path except core_stall.
- IDLE: start=1 -> ARB, idx=0, starve_cnt=0. start ignored in all other states.
- ARB: if core_rd_req=0 or starve_cnt==STARVE_LIMIT -> ISSUE, starve_cnt<=0; else starve_cnt+1, stay.
- ISSUE: rf_port_sel=1, rf_raddr=idx for exactly one cycle -> CAPT. A core request in this cycle yields core_stall=1.
- CAPT: latch rf_rdata into buffer -> SEND.
- SEND: dump_valid=1, dump_addr=idx, dump_data=buffer, all stable until handshake. On dump_valid&dump_ready: if idx==NUM_REGS-1 -> DONE, else idx+1 -> ARB. dump_valid deasserts the cycle after acceptance.
- DONE: done=1, busy=1 for one cycle -> IDLE; idx resets to 0.
- No special-casing of x0: value is whatever the RF returns (RF holds it at 0).
- Latency, no contention, dump_ready=1: start sampled at edge k; first dump_valid in cycle k+4; register i beat in cycle k+4+4i; done in cycle k+129. Each contention cycle in ARB adds one cycle, at most STARVE_LIMIT per register.
- starve_cnt width clog2(STARVE_LIMIT+1), never exceeds STARVE_LIMIT.

Test Plan:
- RF preloaded r_i=0xA5000000+i, core_rd_req=0, dump_ready=1, start pulse -> 32 beats, beat i dump_addr=i, dump_data=0xA5000000+i (beat 0 = 0), done exactly in cycle k+129, busy low afterwards.
- core_rd_req held 1 throughout, STARVE_LIMIT=8 -> each register spends 9 cycles in ARB, core_stall=1 only in ISSUE cycles (32 total), done at cycle k+385.
- dump_ready=0 for 5 cycles at beat 7 -> dump_valid stays 1, dump_addr=7 and dump_data stable all 5 cycles, no beat lost or duplicated, idx advances only on handshake.
- start pulsed again while busy at beat 10 -> ignored; sequence and done timing unchanged; single done pulse.
- rstb=0 for one cycle during SEND of beat 15 -> all outputs 0 next cycle, state IDLE, no done; fresh start rescans from index 0.
- core_rd_req toggling 1,0 each cycle -> no stall beyond ISSUE cycles, rf_port_sel never high for two consecutive cycles, all 32 values correct.
